msx_status_writer: RTL and testbench
====================================

MSX_STATUS_WRITER -- requirements
Module: msx_status_writer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: number of cycles to wait for HPS echo before abandoning a write.
REQ-002 SHALL have parameter DEPTH, default 4: request queue depth when queueing is compiled in.
REQ-003 SHALL have port clk, input, 1: single core clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port HPS_status, input, 64: current OSD status word from HPS.
REQ-006 SHALL have port req_valid, input, 1: field-write request strobe.
REQ-007 SHALL have port req_ready, output, 1: request accepted when req_valid & req_ready at a clock edge.
REQ-008 SHALL have port req_lsb, input, 6: field LSB bit index in the status word.
REQ-009 SHALL have port req_width, input, 3: field width in bits, legal 1..4.
REQ-010 SHALL have port req_value, input, 4: new field value, right-aligned; bits above req_width ignored.
REQ-011 SHALL have port status_out, output, 64: registered status word offered to HPS.
REQ-012 SHALL have port status_set, output, 1: one-cycle pulse telling HPS to latch status_out.
REQ-013 SHALL have port busy, output, 1: high when the FSM is not IDLE or the queue is non-empty.
REQ-014 SHALL have port err_timeout, output, 1: sticky, set when a write is not echoed within TIMEOUT cycles.
REQ-015 SHALL have port err_range, output, 1: sticky, set when a request has width 0, width > 4, or lsb+width > 64.
REQ-016 SHALL have port err_clear, input, 1: clears both sticky error flags.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SET, WAIT.
- IDLE -> LOAD: when an entry is available, popping it.
- LOAD: on a range-illegal entry, set err_range and return to IDLE. On a field already equal to the masked value in HPS_status, return to IDLE with no write. Otherwise load status_out = HPS_status with the field replaced and go to SET.
REQ-018 SHALL drive status_set high for exactly one cycle in SET, then enter WAIT with the timeout counter cleared.
REQ-019 SHALL leave WAIT for IDLE when the field in HPS_status equals the written value, or when the counter reaches TIMEOUT-1; the timeout exit also sets err_timeout.
REQ-020 SHALL give fixed latency: a request accepted at edge N, with empty queue and FSM in IDLE, is in LOAD in cycle N+1 and has status_set high in cycle N+2.
REQ-021 SHALL hold status_out unchanged outside LOAD and keep the full word; bits outside the field are copied from HPS_status sampled in LOAD.
REQ-022 SHALL process requests strictly in acceptance order, one write in flight at a time.
REQ-023 SHALL deassert req_ready when the queue is full, with no same-cycle pop-bypass.
REQ-024 SHALL give a new error event priority over err_clear in the same cycle.
REQ-025 SHALL compute lsb+width at 7-bit width so that no wrap-around hides a range error.

Reset
REQ-026 SHALL on reset_n low at a clock edge set: FSM to IDLE; queue to empty; status_out to 0; status_set to 0; busy to 0; err_timeout and err_range to 0; timeout counter to 0; req_ready to 0 while reset_n is low.
REQ-027 SHALL abandon any in-flight write on reset mid-operation, with no further status_set pulse.

Configuration
REQ-028 SHALL implement, with macro MSX_STATUS_WRITER_QUEUE_EN defined, a DEPTH-entry FIFO; req_ready is high whenever the FIFO is not full.
REQ-029 SHALL implement, without MSX_STATUS_WRITER_QUEUE_EN, a single holding register; req_ready is high only when the FSM is IDLE and the register is empty, and DEPTH is ignored.

Verification
REQ-030 SHALL cover the basic write: HPS_status=0, request lsb=17 width=3 value=7 at edge N -> status_set pulse in cycle N+2 only, status_out=0x00000000000E0000; HPS_status echoes 0x000E0000 -> busy=0 on the following cycle.
REQ-031 SHALL cover the already-equal case: HPS_status[19:17]=7, same request -> no status_set; busy returns to 0 by cycle N+2.
REQ-032 SHALL cover timeout: request lsb=32 width=4 value=5, HPS_status never echoes -> err_timeout=1 after 1024 cycles in WAIT; next queued request is then processed.
REQ-033 SHALL cover range errors: request lsb=62 width=4 -> err_range=1, no status_set; err_clear pulse -> err_range=0.
REQ-034 SHALL cover a full queue (QUEUE_EN, DEPTH=4): 5 back-to-back requests while in WAIT -> req_ready=0 on the 5th until one entry pops; status_set pulses occur in acceptance order.
REQ-035 SHALL cover reset mid-operation: reset_n low in WAIT for one edge -> status_out=0, busy=0, queue empty; no status_set after release.

Source files
------------

// File: rtl/msx_status_writer.sv
// msx_status_writer: applies queued field-write requests to the HPS OSD status
// word. Each write is offered to HPS with a one-cycle status_set pulse, then
// waits for HPS to echo the new field or for a timeout.
// Optional feature macro: MSX_STATUS_WRITER_QUEUE_EN selects a DEPTH-entry
// request FIFO; without it a single holding register is used.
module msx_status_writer #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] HPS_status,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_lsb,
  input  logic [2:0]  req_width,
  input  logic [3:0]  req_value,
  output logic [63:0] status_out,
  output logic        status_set,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_range,
  input  logic        err_clear
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [5:0] lsb;
    logic [2:0] width;
    logic [3:0] value;
  } req_t;

  typedef enum logic [1:0] {IDLE, LOAD, SET, WAIT} state_t;

  state_t        state, next;
  req_t          in_req, head, cur;
  logic [CW-1:0] count;
  logic          push, pop;
  logic          load_en, range_hit, timeout_hit;
  logic [TW-1:0] cnt;
  logic [3:0]    wmask;
  logic [63:0]   fmask, fval, merged;
  logic [6:0]    lsb_end;
  logic          range_bad, field_match;

  assign in_req = '{lsb: req_lsb, width: req_width, value: req_value};
  assign push   = req_valid && req_ready;

`ifdef MSX_STATUS_WRITER_QUEUE_EN
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full;

  assign full      = (count == CW'(DEPTH));
  assign req_ready = reset_n && !full;
  assign head      = mem[rd_ptr];

  // Circular FIFO: write on accept, read on IDLE pop; occupancy tracked in count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_req;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
`else
  req_t hold;

  assign req_ready = reset_n && (state == IDLE) && (count == '0);
  assign head      = hold;

  // Single holding register; accept and pop are mutually exclusive here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold  <= '0;
      count <= '0;
    end else if (push) begin
      hold  <= in_req;
      count <= CW'(1);
    end else if (pop) begin
      count <= '0;
    end
  end
`endif

  // Field mask/value for the entry in flight; lsb+width kept at 7 bits.
  always_comb begin
    case (cur.width)
      3'd1:    wmask = 4'b0001;
      3'd2:    wmask = 4'b0011;
      3'd3:    wmask = 4'b0111;
      3'd4:    wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
    lsb_end     = {1'b0, cur.lsb} + {4'b0000, cur.width};
    range_bad   = (cur.width == 3'd0) || (cur.width > 3'd4) || (lsb_end > 7'd64);
    fmask       = {60'b0, wmask} << cur.lsb;
    fval        = {60'b0, cur.value & wmask} << cur.lsb;
    merged      = (HPS_status & ~fmask) | fval;
    field_match = ((HPS_status & fmask) == fval);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  // Next-state and control strobes.
  always_comb begin
    next        = state;
    pop         = 1'b0;
    load_en     = 1'b0;
    range_hit   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop  = 1'b1;
          next = LOAD;
        end
      end
      LOAD: begin
        if (range_bad) begin
          range_hit = 1'b1;
          next      = IDLE;
        end else if (field_match) begin
          next = IDLE;
        end else begin
          load_en = 1'b1;
          next    = SET;
        end
      end
      SET: next = WAIT;
      WAIT: begin
        if (field_match) begin
          next = IDLE;
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next        = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  // Datapath: current entry, output word, echo timer and sticky errors.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur         <= '0;
      status_out  <= '0;
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (pop)     cur        <= head;
      if (load_en) status_out <= merged;
      if (state == SET)       cnt <= '0;
      else if (state == WAIT) cnt <= cnt + TW'(1);
      // A fresh error event wins over a same-cycle clear.
      if (range_hit)      err_range <= 1'b1;
      else if (err_clear) err_range <= 1'b0;
      if (timeout_hit)    err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

  assign status_set = (state == SET);
  assign busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_msx_status_writer.sv
// Scoreboard bench for msx_status_writer: stimulus pushes each expected
// status_out word; a monitor pops and compares on every status_set pulse.
module tb_msx_status_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] HPS_status;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_lsb;
  logic [2:0]  req_width;
  logic [3:0]  req_value;
  logic [63:0] status_out;
  logic        status_set;
  logic        busy;
  logic        err_timeout;
  logic        err_range;
  logic        err_clear;

  int          checks = 0;
  int          errors = 0;
  int          pulse_count = 0;
  int          npe = 0;
  logic [63:0] sb [$];

  msx_status_writer #(.TIMEOUT(1024), .DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .HPS_status(HPS_status),
    .req_valid(req_valid), .req_ready(req_ready), .req_lsb(req_lsb),
    .req_width(req_width), .req_value(req_value), .status_out(status_out),
    .status_set(status_set), .busy(busy), .err_timeout(err_timeout),
    .err_range(err_range), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every status_set pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (status_set === 1'b1) begin
      pulse_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_set: got status_set=1 status_out=%h required no pulse", status_out);
      end else begin
        check("sb_status_out", status_out, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [63:0] w);
    sb.push_back(w);
    npe++;
  endtask

  task automatic issue(input logic [5:0] l, input logic [2:0] w, input logic [3:0] v);
    bit ok = 1'b0;
    req_lsb   = l;
    req_width = w;
    req_value = v;
    req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    req_valid = 1'b0;
    check("issue_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_pulse(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (pulse_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_pulse", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle", 64'(ok), 64'd1);
    tick();
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end

  initial begin
    int at;
    logic [5:0]  q_lsb [5];
    logic [3:0]  q_val [5];
    logic [63:0] q_exp [5];
    reset_n    = 1'b0;
    HPS_status = '0;
    req_valid  = 1'b0;
    req_lsb    = '0;
    req_width  = '0;
    req_value  = '0;
    err_clear  = 1'b0;

    // Reset state
    tick();
    tick();
    @(negedge clk);
    check("rst_status_out", status_out, 64'd0);
    check("rst_status_set", 64'(status_set), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_err_range", 64'(err_range), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    tick();

    // Basic write with fixed latency, then HPS echo
    expect_write(64'h00000000000E0000);
    issue(6'd17, 3'd3, 4'd7);
    @(negedge clk);
    check("lat_n0_set", 64'(status_set), 64'd0);
    check("lat_n0_busy", 64'(busy), 64'd1);
`ifndef MSX_STATUS_WRITER_QUEUE_EN
    check("hold_full_ready", 64'(req_ready), 64'd0);
`endif
    tick();
    @(negedge clk);
    check("lat_n1_set", 64'(status_set), 64'd0);
    tick();
    @(negedge clk);
    check("lat_n2_set", 64'(status_set), 64'd1);
    check("lat_n2_out", status_out, 64'h00000000000E0000);
    tick();
    HPS_status = 64'h00000000000E0000;
    @(negedge clk);
    check("lat_n3_set", 64'(status_set), 64'd0);
    check("lat_n3_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("echo_busy", 64'(busy), 64'd0);
    tick();

    // Already-equal field: no write
    issue(6'd17, 3'd3, 4'd7);
    tick();
    tick();
    @(negedge clk);
    check("equal_busy", 64'(busy), 64'd0);
    tick();

    // Range errors and clear
    issue(6'd62, 3'd4, 4'hF);
    tick();
    tick();
    @(negedge clk);
    check("range_62_4", 64'(err_range), 64'd1);
    check("range_busy", 64'(busy), 64'd0);
    tick();
    clear_errors();
    @(negedge clk);
    check("range_cleared", 64'(err_range), 64'd0);
    tick();
    issue(6'd0, 3'd0, 4'h1);
    tick();
    tick();
    @(negedge clk);
    check("range_w0", 64'(err_range), 64'd1);
    tick();
    clear_errors();
    issue(6'd0, 3'd5, 4'h1);
    tick();
    tick();
    @(negedge clk);
    check("range_w5", 64'(err_range), 64'd1);
    tick();
    clear_errors();
    // Range error in the same cycle as err_clear: error wins
    issue(6'd63, 3'd2, 4'h3);
    tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    @(negedge clk);
    check("range_priority", 64'(err_range), 64'd1);
    tick();
    clear_errors();
    check("err_timeout_clean", 64'(err_timeout), 64'd0);
    // Legal top-of-word field
    expect_write(64'hA0000000000E0000);
    issue(6'd60, 3'd4, 4'hA);
    wait_pulse(npe);
    HPS_status = 64'hA0000000000E0000;
    wait_idle();

    // Timeout: HPS never echoes; next request then runs
    expect_write(64'hA0000005000E0000);
    issue(6'd32, 3'd4, 4'd5);
    wait_pulse(npe);
    @(negedge clk);
`ifdef MSX_STATUS_WRITER_QUEUE_EN
    check("wait_ready_q", 64'(req_ready), 64'd1);
`else
    check("wait_ready_hold", 64'(req_ready), 64'd0);
`endif
    at = 0;
    for (int k = 1; k <= 1100; k++) begin
      tick();
`ifdef MSX_STATUS_WRITER_QUEUE_EN
      if (k == 5) begin
        req_lsb = 6'd0; req_width = 3'd1; req_value = 4'd1; req_valid = 1'b1;
        expect_write(64'hA0000000000E0001);
      end
      if (k == 6) req_valid = 1'b0;
`endif
      if (err_timeout === 1'b1) begin
        at = k;
        break;
      end
    end
    check("timeout_cycles", 64'(at), 64'd1024);
`ifndef MSX_STATUS_WRITER_QUEUE_EN
    expect_write(64'hA0000000000E0001);
    issue(6'd0, 3'd1, 4'd1);
`endif
    wait_pulse(npe);
    HPS_status = 64'hA0000000000E0001;
    wait_idle();
    check("timeout_sticky", 64'(err_timeout), 64'd1);
    clear_errors();
    @(negedge clk);
    check("timeout_cleared", 64'(err_timeout), 64'd0);
    tick();

`ifdef MSX_STATUS_WRITER_QUEUE_EN
    // Full queue while a write waits; order of writes preserved
    HPS_status = '0;
    q_lsb = '{6'd12, 6'd16, 6'd20, 6'd24, 6'd28};
    q_val = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    q_exp = '{64'h1300, 64'h21300, 64'h321300, 64'h4321300, 64'h54321300};
    expect_write(64'h300);
    issue(6'd8, 3'd4, 4'd3);
    wait_pulse(npe);
    for (int i = 0; i < 4; i++) begin
      req_lsb = q_lsb[i]; req_width = 3'd4; req_value = q_val[i]; req_valid = 1'b1;
      expect_write(q_exp[i]);
      tick();
    end
    req_lsb = q_lsb[4]; req_value = q_val[4];
    @(negedge clk);
    check("full_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    @(negedge clk);
    check("full_ready_hold", 64'(req_ready), 64'd0);
    tick();
    HPS_status = 64'h300;
    at = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        at = 1;
        break;
      end
    end
    check("full_ready_after_pop", 64'(at), 64'd1);
    tick();
    req_valid = 1'b0;
    expect_write(q_exp[4]);
    for (int i = 0; i < 5; i++) begin
      wait_pulse(npe - 4 + i);
      HPS_status = q_exp[i];
    end
    wait_idle();
`else
    q_lsb = '{default: '0};
    q_val = '{default: '0};
    q_exp = '{default: '0};
`endif

    // Reset while waiting for echo
    HPS_status = '0;
    expect_write(64'h90);
    issue(6'd4, 3'd4, 4'd9);
    wait_pulse(npe);
`ifdef MSX_STATUS_WRITER_QUEUE_EN
    issue(6'd8, 3'd4, 4'd1);
`endif
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(req_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_status_out", status_out, 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    check("midrst_busy_later", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("pulse_total", 64'(pulse_count), 64'(npe));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
